pipelined_prefix_adder: RTL and testbench



---
 rtl/pipelined_prefix_adder.sv | 241 ++++++++++++++++++++++++
 tb/tb_pipelined_prefix_adder.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor with a valid/ready stream interface.
// Rank 1 captures the operands, middle ranks split the prefix tree, and the last rank holds the result and flags.
module pipelined_prefix_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int LEVELS    = $clog2(WIDTH);
    localparam int MID_RANKS = (STAGES > 2) ? STAGES - 2 : 0;

    // Middle rank r sits after prefix level floor(r*LEVELS/(MID_RANKS+1)), which keeps the ranks evenly spaced.
    function automatic bit rank_after_level(input int level);
        bit hit;
        hit = 1'b0;
        for (int r = 1; r <= MID_RANKS; r++) begin
            if ((r * LEVELS) / (MID_RANKS + 1) == level) hit = 1'b1;
        end
        return hit;
    endfunction

    logic adv;
    logic out_valid_q;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_sub;
    logic             op_v;

    if (STAGES > 1) begin : g_capture
        logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
        logic             cin_d, cin_q, sub_d, sub_q, v_d, v_q;

        // NOTE: every variable gets its hold value first, so no path through the block leaves it unassigned and no latch is inferred.
        always_comb begin
            a_d   = a_q;
            b_d   = b_q;
            cin_d = cin_q;
            sub_d = sub_q;
            v_d   = v_q;
            if (adv) begin
                a_d   = a;
                b_d   = b;
                cin_d = cin;
                sub_d = sub;
                v_d   = in_valid;
            end
        end

        // NOTE: non-blocking assignment makes every flop sample the pre-edge values, whatever the statement order.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) v_q <= 1'b0;
            else     v_q <= v_d;
        end

        // NOTE: payload flops take no reset; their contents are ignored while the matching valid bit is low.
        always_ff @(posedge clk) begin
            a_q   <= a_d;
            b_q   <= b_d;
            cin_q <= cin_d;
            sub_q <= sub_d;
        end

        assign op_a   = a_q;
        assign op_b   = b_q;
        assign op_cin = cin_q;
        assign op_sub = sub_q;
        assign op_v   = v_q;
    end else begin : g_direct
        assign op_a   = a;
        assign op_b   = b;
        assign op_cin = cin;
        assign op_sub = sub;
        assign op_v   = in_valid;
    end

    logic [WIDTH-1:0] g_lvl  [0:LEVELS];
    logic [WIDTH-1:0] p_lvl  [0:LEVELS-1];
    logic [WIDTH-1:0] hs_lvl [0:LEVELS];
    logic             c_lvl  [0:LEVELS];
    logic             v_lvl  [0:LEVELS];

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] hs0;
    logic [WIDTH-1:0] g0;
    logic             c0;

    always_comb begin
        b_eff = op_sub ? ~op_b : op_b;
        c0    = op_sub ? ~op_cin : op_cin;
        hs0   = op_a ^ b_eff;
        g0    = op_a & b_eff;
        // Carry-in is a generate at position -1; folding it into bit 0 keeps the tree WIDTH bits wide.
        g0[0] = g0[0] | (hs0[0] & c0);
    end

    assign g_lvl[0]  = g0;
    assign p_lvl[0]  = hs0;
    assign hs_lvl[0] = hs0;
    assign c_lvl[0]  = c0;
    assign v_lvl[0]  = op_v;

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
        localparam int DIST = 1 << (k - 1);
        logic [WIDTH-1:0] g_nxt;

        always_comb begin
            g_nxt = g_lvl[k-1];
            for (int i = DIST; i < WIDTH; i++) begin
                g_nxt[i] = g_lvl[k-1][i] | (p_lvl[k-1][i] & g_lvl[k-1][i-DIST]);
            end
        end

        if (k == LEVELS) begin : g_last
            assign g_lvl[k]  = g_nxt;
            assign hs_lvl[k] = hs_lvl[k-1];
            assign c_lvl[k]  = c_lvl[k-1];
            assign v_lvl[k]  = v_lvl[k-1];
        end else begin : g_mid
            logic [WIDTH-1:0] p_nxt;

            always_comb begin
                p_nxt = p_lvl[k-1];
                for (int i = DIST; i < WIDTH; i++) begin
                    p_nxt[i] = p_lvl[k-1][i] & p_lvl[k-1][i-DIST];
                end
            end

            if (rank_after_level(k)) begin : g_rank
                logic [WIDTH-1:0] g_d, g_q, p_d, p_q, hs_d, hs_q;
                logic             c_d, c_q, v_d, v_q;

                always_comb begin
                    g_d  = g_q;
                    p_d  = p_q;
                    hs_d = hs_q;
                    c_d  = c_q;
                    v_d  = v_q;
                    if (adv) begin
                        g_d  = g_nxt;
                        p_d  = p_nxt;
                        hs_d = hs_lvl[k-1];
                        c_d  = c_lvl[k-1];
                        v_d  = v_lvl[k-1];
                    end
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) v_q <= 1'b0;
                    else     v_q <= v_d;
                end

                always_ff @(posedge clk) begin
                    g_q  <= g_d;
                    p_q  <= p_d;
                    hs_q <= hs_d;
                    c_q  <= c_d;
                end

                assign g_lvl[k]  = g_q;
                assign p_lvl[k]  = p_q;
                assign hs_lvl[k] = hs_q;
                assign c_lvl[k]  = c_q;
                assign v_lvl[k]  = v_q;
            end else begin : g_wire
                assign g_lvl[k]  = g_nxt;
                assign p_lvl[k]  = p_nxt;
                assign hs_lvl[k] = hs_lvl[k-1];
                assign c_lvl[k]  = c_lvl[k-1];
                assign v_lvl[k]  = v_lvl[k-1];
            end
        end
    end

    logic [WIDTH-1:0] carry_in;
    logic [WIDTH-1:0] res_sum;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             out_valid_d;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             zero_d, zero_q;

    // Bubbles only clear out_valid; the result fields keep describing the last real result.
    always_comb begin
        carry_in    = {g_lvl[LEVELS][WIDTH-2:0], c_lvl[LEVELS]};
        res_sum     = hs_lvl[LEVELS] ^ carry_in;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (adv) begin
            out_valid_d = v_lvl[LEVELS];
            if (v_lvl[LEVELS]) begin
                sum_d  = res_sum;
                cout_d = g_lvl[LEVELS][WIDTH-1];
                ovf_d  = g_lvl[LEVELS][WIDTH-1] ^ g_lvl[LEVELS][WIDTH-2];
                zero_d = (res_sum == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Bench for pipelined_prefix_adder: directed table on 32/3, streams with stalls and reset
// on 32/3, a near-exhaustive sweep on 8/1 and a patterned sweep on 64/7.
module tb_pipelined_prefix_adder;
    localparam int S32 = 3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
        logic        exp_zero;
    } vec_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic        sub;
    } stim_t;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int          sel;
    logic        t_in_valid, t_out_ready, t_cin, t_sub;
    logic [63:0] t_a, t_b;

    logic        m_in_ready, m_out_valid, m_cout, m_ovf, m_zero;
    logic [63:0] m_sum;

    logic        iv8, ir8, or8, ov8, co8, of8, z8;
    logic [7:0]  s8;
    logic        iv32, ir32, or32, ov32, co32, of32, z32;
    logic [31:0] s32;
    logic        iv64, ir64, or64, ov64, co64, of64, z64;
    logic [63:0] s64;

    assign iv8  = (sel == 1) && t_in_valid;
    assign or8  = (sel == 1) ? t_out_ready : 1'b1;
    assign iv32 = (sel == 0) && t_in_valid;
    assign or32 = (sel == 0) ? t_out_ready : 1'b1;
    assign iv64 = (sel == 2) && t_in_valid;
    assign or64 = (sel == 2) ? t_out_ready : 1'b1;

    pipelined_prefix_adder #(.WIDTH(32), .STAGES(S32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(t_a[31:0]), .b(t_b[31:0]),
        .cin(t_cin), .sub(t_sub), .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32),
        .ovf(of32), .zero(z32));

    pipelined_prefix_adder #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(t_a[7:0]), .b(t_b[7:0]),
        .cin(t_cin), .sub(t_sub), .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8),
        .ovf(of8), .zero(z8));

    pipelined_prefix_adder #(.WIDTH(64), .STAGES(7)) u_dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(t_a), .b(t_b),
        .cin(t_cin), .sub(t_sub), .out_valid(ov64), .out_ready(or64), .sum(s64), .cout(co64),
        .ovf(of64), .zero(z64));

    always_comb begin
        m_in_ready  = ir32;
        m_out_valid = ov32;
        m_sum       = {32'd0, s32};
        m_cout      = co32;
        m_ovf       = of32;
        m_zero      = z32;
        if (sel == 1) begin
            m_in_ready  = ir8;
            m_out_valid = ov8;
            m_sum       = {56'd0, s8};
            m_cout      = co8;
            m_ovf       = of8;
            m_zero      = z8;
        end else if (sel == 2) begin
            m_in_ready  = ir64;
            m_out_valid = ov64;
            m_sum       = s64;
            m_cout      = co64;
            m_ovf       = of64;
            m_zero      = z64;
        end
    end

    int    n_checks = 0;
    int    n_errors = 0;
    vec_t  vecs [12];
    stim_t stim_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain wide addition, overflow from operand/result sign bits.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic cin, input logic sub, input int w);
        res_t        r;
        logic [64:0] mask, t;
        logic [63:0] am, bb;
        logic        ci;
        mask   = (65'd1 << w) - 65'd1;
        am     = a & mask[63:0];
        bb     = (sub ? ~b : b) & mask[63:0];
        ci     = sub ? ~cin : cin;
        t      = {1'b0, am} + {1'b0, bb} + {64'd0, ci};
        r.sum  = t[63:0] & mask[63:0];
        r.cout = t[w];
        r.ovf  = (am[w-1] == bb[w-1]) && (r.sum[w-1] != am[w-1]);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    task automatic send_one(input vec_t v, input int idx);
        t_a = {32'd0, v.a};
        t_b = {32'd0, v.b};
        t_cin = v.cin;
        t_sub = v.sub;
        t_in_valid = 1'b1;
        t_out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_in_ready", idx), m_in_ready, 1);
        @(posedge clk); #1;
        t_in_valid = 1'b0;
        for (int i = 0; i < S32 - 1; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_early_valid", idx), m_out_valid, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check($sformatf("vec%0d_out_valid", idx), m_out_valid, 1);
        check($sformatf("vec%0d_sum", idx), m_sum, {32'd0, v.exp_sum});
        check($sformatf("vec%0d_cout", idx), m_cout, v.exp_cout);
        check($sformatf("vec%0d_ovf", idx), m_ovf, v.exp_ovf);
        check($sformatf("vec%0d_zero", idx), m_zero, v.exp_zero);
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input int w, input int stall_from, input int stall_len, input string tag);
        res_t        exp_q [$];
        res_t        e;
        int          n, sent, got, cyc, budget;
        logic        hold;
        logic [63:0] held_sum;
        logic        held_cout, held_ovf, held_zero;
        n = stim_q.size();
        sent = 0;
        got = 0;
        cyc = 0;
        hold = 1'b0;
        held_sum = '0;
        held_cout = 1'b0;
        held_ovf = 1'b0;
        held_zero = 1'b0;
        budget = 2 * n + stall_len + 50;
        while (got < n && cyc < budget) begin
            t_in_valid = (sent < n);
            if (sent < n) begin
                t_a = stim_q[sent].a;
                t_b = stim_q[sent].b;
                t_cin = stim_q[sent].cin;
                t_sub = stim_q[sent].sub;
            end
            t_out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            @(negedge clk);
            if (hold) begin
                check({tag, "_frozen_valid"}, m_out_valid, 1);
                check({tag, "_frozen_sum"}, m_sum, held_sum);
                check({tag, "_frozen_flags"}, {m_cout, m_ovf, m_zero}, {held_cout, held_ovf, held_zero});
            end
            if (m_out_valid && !t_out_ready) check({tag, "_stall_in_ready"}, m_in_ready, 0);
            if (t_in_valid && m_in_ready) begin
                exp_q.push_back(model(t_a, t_b, t_cin, t_sub, w));
                sent++;
            end
            if (m_out_valid && t_out_ready) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_unexpected_out"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_sum"}, m_sum, e.sum);
                    check({tag, "_cout"}, m_cout, e.cout);
                    check({tag, "_ovf"}, m_ovf, e.ovf);
                    check({tag, "_zero"}, m_zero, e.zero);
                end
                got++;
            end
            hold = m_out_valid && !t_out_ready;
            held_sum = m_sum;
            held_cout = m_cout;
            held_ovf = m_ovf;
            held_zero = m_zero;
            @(posedge clk); #1;
            cyc++;
        end
        t_in_valid = 1'b0;
        t_out_ready = 1'b1;
        check({tag, "_result_count"}, got, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        vecs[0]  = '{32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000ABCD, 32'h0000ABCD, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{32'h00000005, 32'h00000003, 1'b1, 1'b1, 32'h00000001, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        vecs[10] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};

        sel = 0;
        t_in_valid = 1'b0;
        t_out_ready = 1'b1;
        t_a = '0;
        t_b = '0;
        t_cin = 1'b0;
        t_sub = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            check($sformatf("reset%0d_out_valid", d), m_out_valid, 0);
            check($sformatf("reset%0d_sum", d), m_sum, 0);
            check($sformatf("reset%0d_flags", d), {m_cout, m_ovf, m_zero}, 3'b000);
        end
        sel = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            check($sformatf("reset%0d_in_ready", d), m_in_ready, 1);
        end
        sel = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) send_one(vecs[i], i);

        stim_q.delete();
        for (int i = 0; i < 8; i++) begin
            s.a = {32'd0, $urandom()};
            s.b = {32'd0, $urandom()};
            s.cin = 1'($urandom_range(0, 1));
            s.sub = 1'($urandom_range(0, 1));
            stim_q.push_back(s);
        end
        run_stream(32, 4, 4, "s32");

        // Reset with three operands in flight: everything must vanish at once.
        for (int i = 0; i < 3; i++) begin
            t_a = {32'd0, vecs[i+1].a};
            t_b = {32'd0, vecs[i+1].b};
            t_cin = vecs[i+1].cin;
            t_sub = vecs[i+1].sub;
            t_in_valid = 1'b1;
            t_out_ready = 1'b1;
            @(posedge clk); #1;
        end
        t_in_valid = 1'b0;
        check("rst_pre_out_valid", m_out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", m_out_valid, 0);
        check("rst_mid_sum", m_sum, 0);
        check("rst_mid_in_ready", m_in_ready, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_no_stale", m_out_valid, 0);
            @(posedge clk); #1;
        end
        send_one(vecs[3], 100);

        sel = 1;
        stim_q.delete();
        for (int av = 0; av < 256; av++) begin
            for (int bv = 0; bv < 256; bv += 3) begin
                s.a = 64'(av);
                s.b = 64'(bv);
                s.cin = 1'((av + bv / 3) % 4);
                s.sub = 1'(((av + bv / 3) % 4) >> 1);
                stim_q.push_back(s);
            end
        end
        run_stream(8, 100, 5, "s8");

        sel = 2;
        stim_q.delete();
        s = '{64'hFFFFFFFFFFFFFFFF, 64'h1, 1'b1, 1'b0}; stim_q.push_back(s);
        s = '{64'h7FFFFFFFFFFFFFFF, 64'h1, 1'b0, 1'b0}; stim_q.push_back(s);
        s = '{64'h8000000000000000, 64'h1, 1'b0, 1'b1}; stim_q.push_back(s);
        s = '{64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 1'b0, 1'b1}; stim_q.push_back(s);
        s = '{64'h0, 64'h0, 1'b1, 1'b1}; stim_q.push_back(s);
        for (int i = 0; i < 64; i++) begin
            s.a = {$urandom(), $urandom()};
            s.b = (i % 4 == 0) ? ~s.a : {$urandom(), $urandom()};
            s.cin = 1'($urandom_range(0, 1));
            s.sub = 1'($urandom_range(0, 1));
            stim_q.push_back(s);
        end
        run_stream(64, 12, 6, "s64");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
